// File: rtl/wb_bus_arbiter.sv
// Wishbone classic bus arbiter for an instruction-fetch port and a data port.
// Data requests have fixed priority over fetches. Each granted cycle ends with
// one DONE cycle, so a requester sees its ack before the next arbitration.
// A saturating wait counter forces termination of a bus cycle if the slave
// never acknowledges.
module wb_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  input  logic        flush,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, I_BUS, D_BUS, DONE} state_t;

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        timeout_q, timeout_d;
  logic [15:0] cnt_q, cnt_d;
  logic        flushed_q, flushed_d;

  // Widened so a saturated counter can never wrap into a false match.
  logic [31:0] cnt_inc;
  logic        timed_out;
  logic        fetch_kill;
  logic [31:0] cap_data;

  // State and registered outputs; reset clears everything, even mid-cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      adr_q     <= 32'h0;
      dat_q     <= 32'h0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= 16'h0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      flushed_q <= flushed_d;
    end
  end

  // Arbitration, bus-cycle termination and result capture.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    timeout_d  = 1'b0;
    cnt_d      = cnt_q;
    flushed_d  = flushed_q;
    cnt_inc    = {16'h0, cnt_q} + 32'd1;
    timed_out  = !wb_ack_i && (cnt_inc >= TIMEOUT_CYC);
    fetch_kill = flushed_q || flush;
    cap_data   = wb_ack_i ? wb_dat_i : 32'h0;

    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d   = D_BUS;
          cyc_d     = 1'b1;
          we_d      = d_we;
          sel_d     = d_sel;
          adr_d     = d_addr;
          dat_d     = d_wdata;
          cnt_d     = 16'h0;
          flushed_d = 1'b0;
        end else if (i_req && !flush) begin
          state_d   = I_BUS;
          cyc_d     = 1'b1;
          we_d      = 1'b0;
          sel_d     = 4'hF;
          adr_d     = i_addr;
          dat_d     = 32'h0;
          cnt_d     = 16'h0;
          flushed_d = 1'b0;
        end
      end
      I_BUS, D_BUS: begin
        if (wb_ack_i || timed_out) begin
          state_d   = DONE;
          cyc_d     = 1'b0;
          timeout_d = !wb_ack_i;
          if (state_q == D_BUS) begin
            d_rdata_d = cap_data;
            d_ack_d   = 1'b1;
          end else if (!fetch_kill) begin
            // A flushed fetch still finishes on the bus but is discarded.
            i_rdata_d = cap_data;
            i_ack_d   = 1'b1;
          end
        end else begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (state_q == I_BUS && flush) flushed_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign timeout_o = timeout_q;

  assign stallreq_if  = rst_n && i_req && !i_ack_q && !flush;
  assign stallreq_mem = rst_n && d_req && !d_ack_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_sel;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        flush;
  logic        stallreq_if, stallreq_mem;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  wb_bus_arbiter #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_sel(d_sel), .d_rdata(d_rdata), .d_ack(d_ack),
    .flush(flush), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; d_sel = 4'h0; flush = 1'b0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0;

    // reset state
    tick(); tick();
    check("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    check("rst_stb", {31'h0, wb_stb_o}, 32'h0);
    check("rst_adr", wb_adr_o, 32'h0);
    check("rst_sel", {28'h0, wb_sel_o}, 32'h0);
    check("rst_acks", {30'h0, i_ack, d_ack}, 32'h0);
    check("rst_stallreq", {30'h0, stallreq_if, stallreq_mem}, 32'h0);
    i_req = 1'b0; d_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // fetch with two wait cycles
    i_req = 1'b1; i_addr = 32'h100;
    #1 check("f_stallreq_if", {31'h0, stallreq_if}, 32'h1);
    tick();
    check("f_cyc", {31'h0, wb_cyc_o}, 32'h1);
    check("f_stb", {31'h0, wb_stb_o}, 32'h1);
    check("f_adr", wb_adr_o, 32'h100);
    check("f_we", {31'h0, wb_we_o}, 32'h0);
    check("f_sel", {28'h0, wb_sel_o}, 32'hF);
    check("f_dat", wb_dat_o, 32'h0);
    tick(); tick();
    check("f_wait_cyc", {31'h0, wb_cyc_o}, 32'h1);
    check("f_wait_ack", {31'h0, i_ack}, 32'h0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h3C01_0000;
    tick();
    check("f_iack", {31'h0, i_ack}, 32'h1);
    check("f_rdata", i_rdata, 32'h3C01_0000);
    check("f_cyc_drop", {31'h0, wb_cyc_o}, 32'h0);
    wb_ack_i = 1'b0; i_req = 1'b0;
    tick();
    check("f_iack_pulse", {31'h0, i_ack}, 32'h0);
    check("f_rdata_hold", i_rdata, 32'h3C01_0000);
    tick();

    // collision: store wins, then fetch
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_sel = 4'hF;
    tick();
    check("c_we", {31'h0, wb_we_o}, 32'h1);
    check("c_adr", wb_adr_o, 32'h2000);
    check("c_dat", wb_dat_o, 32'hDEAD_BEEF);
    check("c_sel", {28'h0, wb_sel_o}, 32'hF);
    d_addr = 32'h9999; d_wdata = 32'h0;
    tick();
    check("c_adr_hold", wb_adr_o, 32'h2000);
    check("c_dat_hold", wb_dat_o, 32'hDEAD_BEEF);
    wb_ack_i = 1'b1; wb_dat_i = 32'h1111_1111;
    tick();
    check("c_dack", {31'h0, d_ack}, 32'h1);
    check("c_iack_first", {31'h0, i_ack}, 32'h0);
    d_req = 1'b0; wb_ack_i = 1'b0;
    tick();
    check("c_done_cyc", {31'h0, wb_cyc_o}, 32'h0);
    check("c_dack_pulse", {31'h0, d_ack}, 32'h0);
    tick();
    check("c_fetch_cyc", {31'h0, wb_cyc_o}, 32'h1);
    check("c_fetch_adr", wb_adr_o, 32'h200);
    check("c_fetch_we", {31'h0, wb_we_o}, 32'h0);
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
    tick();
    check("c_iack", {31'h0, i_ack}, 32'h1);
    check("c_irdata", i_rdata, 32'hCAFE_F00D);
    check("c_no_dack", {31'h0, d_ack}, 32'h0);
    wb_ack_i = 1'b0; i_req = 1'b0;
    tick(); tick();

    // flush while fetch pending
    i_req = 1'b1; i_addr = 32'h300;
    tick();
    check("fl_cyc", {31'h0, wb_cyc_o}, 32'h1);
    flush = 1'b1;
    #1 check("fl_stallreq_if", {31'h0, stallreq_if}, 32'h0);
    tick();
    flush = 1'b0;
    check("fl_not_aborted", {31'h0, wb_cyc_o}, 32'h1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h55AA_55AA;
    tick();
    check("fl_cyc_end", {31'h0, wb_cyc_o}, 32'h0);
    check("fl_no_iack", {31'h0, i_ack}, 32'h0);
    check("fl_irdata_keep", i_rdata, 32'hCAFE_F00D);
    wb_ack_i = 1'b0; i_req = 1'b0;
    tick();
    check("fl_no_iack2", {31'h0, i_ack}, 32'h0);
    tick();

    // flush in IDLE blocks the fetch grant
    i_req = 1'b1; i_addr = 32'h304; flush = 1'b1;
    tick();
    check("fi_blocked", {31'h0, wb_cyc_o}, 32'h0);
    flush = 1'b0;
    tick();
    check("fi_granted", {31'h0, wb_cyc_o}, 32'h1);
    check("fi_adr", wb_adr_o, 32'h304);
    wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
    tick();
    check("fi_iack", {31'h0, i_ack}, 32'h1);
    check("fi_irdata", i_rdata, 32'h1234_5678);
    wb_ack_i = 1'b0; i_req = 1'b0;
    tick(); tick();

    // timeout on a load, granted despite a flush in IDLE
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; d_sel = 4'hF; flush = 1'b1;
    wb_dat_i = 32'hFFFF_FFFF;
    tick();
    flush = 1'b0;
    check("t_granted", {31'h0, wb_cyc_o}, 32'h1);
    check("t_adr", wb_adr_o, 32'h4000);
    tick(); tick(); tick();
    check("t_wait4_cyc", {31'h0, wb_cyc_o}, 32'h1);
    check("t_wait4_to", {31'h0, timeout_o}, 32'h0);
    check("t_wait4_dack", {31'h0, d_ack}, 32'h0);
    tick();
    check("t_cyc_drop", {31'h0, wb_cyc_o}, 32'h0);
    check("t_dack", {31'h0, d_ack}, 32'h1);
    check("t_drdata", d_rdata, 32'h0);
    check("t_pulse", {31'h0, timeout_o}, 32'h1);
    d_req = 1'b0;
    tick();
    check("t_pulse_end", {31'h0, timeout_o}, 32'h0);
    check("t_dack_end", {31'h0, d_ack}, 32'h0);
    tick();

    // stray ack in IDLE is ignored
    wb_ack_i = 1'b1; wb_dat_i = 32'h7777_7777;
    tick();
    check("stray_acks", {30'h0, i_ack, d_ack}, 32'h0);
    check("stray_cyc", {31'h0, wb_cyc_o}, 32'h0);
    wb_ack_i = 1'b0;
    tick();

    // reset in the middle of a data cycle
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h5000; d_wdata = 32'hA5A5_A5A5; d_sel = 4'h3;
    tick();
    check("r_cyc", {31'h0, wb_cyc_o}, 32'h1);
    check("r_sel", {28'h0, wb_sel_o}, 32'h3);
    rst_n = 1'b0;
    tick();
    check("r_cyc0", {31'h0, wb_cyc_o}, 32'h0);
    check("r_stb0", {31'h0, wb_stb_o}, 32'h0);
    check("r_we0", {31'h0, wb_we_o}, 32'h0);
    check("r_adr0", wb_adr_o, 32'h0);
    check("r_dat0", wb_dat_o, 32'h0);
    check("r_irdata0", i_rdata, 32'h0);
    check("r_dack0", {31'h0, d_ack}, 32'h0);
    check("r_stallmem0", {31'h0, stallreq_mem}, 32'h0);
    rst_n = 1'b1;
    #1 check("r_stallmem1", {31'h0, stallreq_mem}, 32'h1);
    tick();
    check("r_post_cyc", {31'h0, wb_cyc_o}, 32'h1);
    check("r_post_adr", wb_adr_o, 32'h5000);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0;
    tick();
    check("r_post_dack", {31'h0, d_ack}, 32'h1);
    wb_ack_i = 1'b0; d_req = 1'b0;
    tick(); tick();

    // back-to-back zero-wait loads: one transfer per 3 cycles
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6000; d_sel = 4'hF; wb_ack_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      wb_dat_i = 32'h1000 + 32'(k);
      tick();
      check("b2b_cyc", {31'h0, wb_cyc_o}, (k % 3 == 0) ? 32'h1 : 32'h0);
      check("b2b_dack", {31'h0, d_ack}, (k % 3 == 1) ? 32'h1 : 32'h0);
      check("b2b_iack", {31'h0, i_ack}, 32'h0);
      check("b2b_stallmem", {31'h0, stallreq_mem}, (k % 3 == 1) ? 32'h0 : 32'h1);
      if (k % 3 == 1) check("b2b_rdata", d_rdata, 32'h1000 + 32'(k));
    end
    d_req = 1'b0; wb_ack_i = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, max cycles a bus cycle waits for wb_ack_i before forced termination.
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_req  in  1  instruction-fetch read request, held until i_ack.
REQ-005 i_addr  in  32  fetch address, stable while i_req high.
REQ-006 i_rdata  out  32  fetched word, valid in i_ack cycle.
REQ-007 i_ack  out  1  one-cycle fetch completion pulse.
REQ-008 d_req, d_we  in  1 each  data-access request; write when d_we=1.
REQ-009 d_addr, d_wdata  in  32 each  data address / write data.
REQ-010 d_sel  in  4  byte lanes.
REQ-011 d_rdata  out  32  load data, valid in d_ack cycle.
REQ-012 d_ack  out  1  one-cycle data completion pulse.
REQ-013 flush  in  1  pipeline flush from exception control.
REQ-014 stallreq_if, stallreq_mem  out  1 each  stall requests to pipeline stall control.
REQ-015 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone classic master controls.
REQ-016 wb_adr_o, wb_dat_o  out  32 each; wb_sel_o  out  4.
REQ-017 wb_dat_i  in  32; wb_ack_i  in  1  slave data / acknowledge.
REQ-018 timeout_o  out  1  one-cycle pulse on forced cycle termination.

Function
REQ-019 FSM states: IDLE, I_BUS, D_BUS, DONE.
REQ-020 IDLE: d_req=1 -> D_BUS; else i_req=1 and flush=0 -> I_BUS; else stay. Data has fixed priority over fetch.
REQ-021 Entering I_BUS/D_BUS: registered wb_cyc_o=wb_stb_o=1 next cycle, address/we/sel/data latched from the granted requester; fetch uses we=0, sel=4'hF, dat_o=0.
REQ-022 Wishbone outputs held constant for the whole cycle regardless of requester input changes.
REQ-023 I_BUS/D_BUS with wb_ack_i=1: drop cyc/stb next cycle, capture wb_dat_i to the requester rdata register, pulse matching ack next cycle, go DONE.
REQ-024 DONE: one idle bus cycle, then IDLE; guarantees a requester sees its ack before re-arbitration.
REQ-025 Minimum latency: req in IDLE at cycle N, cyc/stb at N+1, slave ack at N+1 -> requester ack at N+2.
REQ-026 16-bit wait counter (width fixed, saturating) clears on grant, increments each bus cycle without wb_ack_i; reaching TIMEOUT_CYC terminates cycle as REQ-023 with rdata=0 and timeout_o pulse.
REQ-027 flush during I_BUS: Wishbone cycle not aborted; completes normally but i_ack suppressed and i_rdata unchanged.
REQ-028 flush never suppresses a data cycle (store/load in MEM already committed).
REQ-029 flush in IDLE blocks fetch grant that cycle; data grant unaffected.
REQ-030 stallreq_mem = d_req and not d_ack; stallreq_if = i_req and not i_ack and not flush (combinational).
REQ-031 wb_ack_i outside a bus cycle ignored.
REQ-032 i_ack and d_ack never high in the same cycle.

Reset
REQ-033 rst_n=0 at a clock edge: state IDLE, counter 0, all outputs 0 (cyc, stb, we, sel, adr, dat, rdata, acks, timeout_o) next cycle, including mid-cycle.
REQ-034 During reset stallreq_if/stallreq_mem forced 0.

Verification
REQ-035 Fetch: i_req, i_addr=0x100, slave acks 2 cycles after stb with 0x3C01_0000 -> wb_adr_o=0x100, we=0, i_ack one pulse, i_rdata=0x3C01_0000.
REQ-036 Collision: i_req and d_req (store 0x2000, data 0xDEAD_BEEF, sel 4'hF) same cycle -> store served first, DONE cycle, then fetch; acks in that order.
REQ-037 Flush: flush pulse while I_BUS pending -> cycle completes, no i_ack, stallreq_if=0 during flush.
REQ-038 Timeout: TIMEOUT_CYC=4, slave never acks load -> cyc drops after 4 wait cycles, d_ack with d_rdata=0, timeout_o one pulse.
REQ-039 Reset mid-cycle: rst_n=0 while D_BUS -> cyc/stb 0 next cycle, no ack; post-reset request served normally.
REQ-040 Back-to-back loads, slave zero-wait ack -> one transfer per 3 cycles, every d_ack single-cycle.
